// File: rtl/joojump_processor_pkg.sv
// Shared definitions for the switch poller: FSM encodings, PIO/event widths,
// the switch PIO address and the event payload layout.
package joojump_processor_pkg;

  localparam int PIO_DW = 8;
  localparam int EVT_DW = 16;

  localparam logic [1:0] SWITCH_PIO_ADDR = 2'd0;

  typedef logic [1:0] state_t;
  localparam state_t ST_WAIT_TICK = 2'd0;
  localparam state_t ST_READ      = 2'd1;
  localparam state_t ST_CAPTURE   = 2'd2;

  typedef struct packed {
    logic [PIO_DW-1:0] changed_mask;
    logic [PIO_DW-1:0] new_value;
  } evt_t;

  function automatic evt_t make_evt(input logic [PIO_DW-1:0] new_value,
                                    input logic [PIO_DW-1:0] prev_value);
    evt_t e;
    e.changed_mask = new_value ^ prev_value;
    e.new_value    = new_value;
    return e;
  endfunction

endpackage

// File: rtl/joojump_processor_debounce8.sv
// 8-bit sample debouncer: a value is accepted once it has been seen on
// STABLE_SAMPLES consecutive samples and differs from the current output.
module joojump_processor_debounce8
  import joojump_processor_pkg::*;
#(
  parameter int STABLE_SAMPLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_en_i,
  input  logic [PIO_DW-1:0] sample_i,
  input  logic [PIO_DW-1:0] current_i,
  output logic              accept_o,
  output logic [PIO_DW-1:0] value_o
);

  localparam logic [3:0] STABLE_MAX = 4'(STABLE_SAMPLES);

  logic [PIO_DW-1:0] candidate_q, candidate_d;
  logic [3:0]        stable_cnt_q, stable_cnt_d;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    candidate_d  = candidate_q;
    stable_cnt_d = stable_cnt_q;
    if (sample_en_i) begin
      if (sample_i == candidate_q) begin
        if (stable_cnt_q < STABLE_MAX) stable_cnt_d = stable_cnt_q + 4'd1;
      end else begin
        candidate_d  = sample_i;
        stable_cnt_d = 4'd1;
      end
    end
  end

  // Acceptance looks at the post-update count so the output moves on the same edge.
  assign accept_o = sample_en_i && (stable_cnt_d == STABLE_MAX) && (candidate_d != current_i);
  assign value_o  = candidate_d;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      candidate_q  <= '0;
      stable_cnt_q <= '0;
    end else begin
      candidate_q  <= candidate_d;
      stable_cnt_q <= stable_cnt_d;
    end
  end

endmodule

// File: rtl/joojump_processor_switch_poller.sv
// Periodically reads the switch PIO over Avalon-MM, debounces the value and
// posts change events through a single-entry valid/ready register.
module joojump_processor_switch_poller
  import joojump_processor_pkg::*;
#(
  parameter int POLL_CYCLES    = 50000,
  parameter int STABLE_SAMPLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic [1:0]        address_o,
  output logic              read_o,
  input  logic [31:0]       readdata_i,
  output logic [PIO_DW-1:0] switch_state_o,
  output logic              evt_valid_o,
  input  logic              evt_ready_i,
  output logic [EVT_DW-1:0] evt_data_o,
  output logic [7:0]        drop_count_o
);

  localparam int            TW        = $clog2(POLL_CYCLES);
  localparam logic [TW-1:0] TICK_LAST = TW'(POLL_CYCLES - 1);

  state_t            state_q, state_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [PIO_DW-1:0] switch_state_q, switch_state_d;
  logic              evt_valid_q, evt_valid_d;
  evt_t              evt_q, evt_d;
  logic [7:0]        drop_q, drop_d;

  logic              capture;
  logic              accept;
  logic [PIO_DW-1:0] accept_value;
  logic              handshake;
  logic              unused_rd_bits;

  assign capture        = (state_q == ST_CAPTURE);
  assign handshake      = evt_valid_q & evt_ready_i;
  assign unused_rd_bits = ^readdata_i[31:PIO_DW];

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    case (state_q)
      ST_WAIT_TICK: begin
        if (tick_q == TICK_LAST) begin
          tick_d  = '0;
          state_d = ST_READ;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      ST_READ:    state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_WAIT_TICK;
      default:    state_d = ST_WAIT_TICK;
    endcase
  end

  joojump_processor_debounce8 #(
    .STABLE_SAMPLES(STABLE_SAMPLES)
  ) u_debounce (
    .clk         (clk),
    .reset       (reset),
    .sample_en_i (capture),
    .sample_i    (readdata_i[PIO_DW-1:0]),
    .current_i   (switch_state_q),
    .accept_o    (accept),
    .value_o     (accept_value)
  );

  // A handshake on the same edge frees the slot, so a new event never drops then.
  always_comb begin
    switch_state_d = switch_state_q;
    evt_valid_d    = evt_valid_q;
    evt_d          = evt_q;
    drop_d         = drop_q;
    if (accept) begin
      switch_state_d = accept_value;
      if (!evt_valid_q || handshake) begin
        evt_valid_d = 1'b1;
        evt_d       = make_evt(accept_value, switch_state_q);
      end else if (drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end
    end else if (handshake) begin
      evt_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_WAIT_TICK;
      tick_q         <= '0;
      switch_state_q <= '0;
      evt_valid_q    <= 1'b0;
      evt_q          <= '0;
      drop_q         <= '0;
    end else begin
      state_q        <= state_d;
      tick_q         <= tick_d;
      switch_state_q <= switch_state_d;
      evt_valid_q    <= evt_valid_d;
      evt_q          <= evt_d;
      drop_q         <= drop_d;
    end
  end

  assign address_o      = SWITCH_PIO_ADDR;
  assign read_o         = (state_q == ST_READ);
  assign switch_state_o = switch_state_q;
  assign evt_valid_o    = evt_valid_q;
  assign evt_data_o     = evt_q;
  assign drop_count_o   = drop_q;

endmodule

// File: tb/tb_joojump_processor_switch_poller.sv
// Directed bench for the switch poller with POLL_CYCLES=4, STABLE_SAMPLES=3.
module tb_joojump_processor_switch_poller;

  localparam int POLL   = 4;
  localparam int STABLE = 3;
  localparam int PERIOD = POLL + 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        read;
  logic [31:0] readdata;
  logic [7:0]  switch_state;
  logic        evt_valid;
  logic        evt_ready;
  logic [15:0] evt_data;
  logic [7:0]  drop_count;

  int n_cmp = 0;
  int n_err = 0;

  joojump_processor_switch_poller #(
    .POLL_CYCLES    (POLL),
    .STABLE_SAMPLES (STABLE)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .address_o      (address),
    .read_o         (read),
    .readdata_i     (readdata),
    .switch_state_o (switch_state),
    .evt_valid_o    (evt_valid),
    .evt_ready_i    (evt_ready),
    .evt_data_o     (evt_data),
    .drop_count_o   (drop_count)
  );

  always #5 clk = ~clk;

  // Outputs are sampled 1ns after the rising edge; inputs change at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // One poll: wait for read, present cap only during CAPTURE, return in the cycle after CAPTURE.
  // ready_cap >= 0 drives evt_ready during the CAPTURE cycle.
  task automatic poll(input logic [31:0] cap, input logic [31:0] other, input int ready_cap);
    int cyc;
    readdata = other;
    cyc = 0;
    while (!read && cyc < 3 * PERIOD) begin
      tick();
      cyc++;
    end
    n_cmp++;
    if (read !== 1'b1) begin
      n_err++;
      $display("FAIL poll_read_timeout: read=%b after %0d cycles, required 1", read, cyc);
    end
    tick();
    readdata = cap;
    if (ready_cap >= 0) evt_ready = ready_cap[0];
    n_cmp++;
    if (read !== 1'b0) begin
      n_err++;
      $display("FAIL read_one_cycle: read=%b in CAPTURE, required 0", read);
    end
    tick();
    readdata = other;
  endtask

  task automatic test_reset();
    readdata  = 32'h0000_00FF;
    evt_ready = 1'b0;
    reset     = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({address, read, switch_state, evt_valid, evt_data, drop_count} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: addr=%h read=%b sw=%h v=%b data=%h drop=%h, required all 0",
               address, read, switch_state, evt_valid, evt_data, drop_count);
    end
    readdata = 32'h0;
    reset    = 1'b0;
    begin
      int cyc = 0;
      while (!read && cyc < 20) begin
        tick();
        cyc++;
      end
      n_cmp++;
      if (cyc != POLL || read !== 1'b1) begin
        n_err++;
        $display("FAIL first_read_latency: got %0d cycles, required %0d", cyc, POLL);
      end
    end
  endtask

  task automatic test_idle();
    for (int p = 0; p < 3; p++) begin
      int cyc = 1;
      bit seen_evt = 1'b0;
      bit bad_addr = 1'b0;
      tick();
      while (!read && cyc < 20) begin
        if (evt_valid !== 1'b0) seen_evt = 1'b1;
        if (address !== 2'd0) bad_addr = 1'b1;
        tick();
        cyc++;
      end
      n_cmp++;
      if (cyc != PERIOD) begin
        n_err++;
        $display("FAIL poll_period: got %0d cycles, required %0d", cyc, PERIOD);
      end
      n_cmp++;
      if (seen_evt || bad_addr || switch_state !== 8'h00) begin
        n_err++;
        $display("FAIL idle_quiet: evt_seen=%b bad_addr=%b sw=%h, required 0/0/00",
                 seen_evt, bad_addr, switch_state);
      end
    end
  endtask

  task automatic test_glitch();
    poll(32'h05, 32'h00, -1);
    n_cmp++;
    if (evt_valid !== 1'b0 || switch_state !== 8'h00) begin
      n_err++;
      $display("FAIL glitch_single: v=%b sw=%h, required 0/00", evt_valid, switch_state);
    end
    for (int p = 0; p < STABLE; p++) begin
      poll(32'h00, 32'h00, -1);
      n_cmp++;
      if (evt_valid !== 1'b0 || switch_state !== 8'h00) begin
        n_err++;
        $display("FAIL glitch_return%0d: v=%b sw=%h, required 0/00", p, evt_valid, switch_state);
      end
    end
  endtask

  task automatic test_change();
    evt_ready = 1'b1;
    for (int p = 0; p < STABLE - 1; p++) begin
      poll(32'h05, 32'h00, -1);
      n_cmp++;
      if (evt_valid !== 1'b0 || switch_state !== 8'h00) begin
        n_err++;
        $display("FAIL change_early%0d: v=%b sw=%h, required 0/00", p, evt_valid, switch_state);
      end
    end
    poll(32'h05, 32'h00, -1);
    n_cmp++;
    if (evt_valid !== 1'b1 || evt_data !== 16'h0505 || switch_state !== 8'h05) begin
      n_err++;
      $display("FAIL change_accept: v=%b data=%h sw=%h, required 1/0505/05",
               evt_valid, evt_data, switch_state);
    end
    tick();
    n_cmp++;
    if (evt_valid !== 1'b0 || switch_state !== 8'h05) begin
      n_err++;
      $display("FAIL change_pulse: v=%b sw=%h, required 0/05", evt_valid, switch_state);
    end
  endtask

  task automatic test_drop();
    do_reset();
    evt_ready = 1'b0;
    for (int p = 0; p < STABLE; p++) poll(32'h01, 32'h01, -1);
    n_cmp++;
    if (evt_valid !== 1'b1 || evt_data !== 16'h0101 || switch_state !== 8'h01) begin
      n_err++;
      $display("FAIL drop_first: v=%b data=%h sw=%h, required 1/0101/01",
               evt_valid, evt_data, switch_state);
    end
    for (int p = 0; p < STABLE; p++) poll(32'h03, 32'h03, -1);
    n_cmp++;
    if (evt_valid !== 1'b1 || evt_data !== 16'h0101 || switch_state !== 8'h03 ||
        drop_count !== 8'd1) begin
      n_err++;
      $display("FAIL drop_second: v=%b data=%h sw=%h drop=%0d, required 1/0101/03/1",
               evt_valid, evt_data, switch_state, drop_count);
    end
    evt_ready = 1'b1;
    tick();
    n_cmp++;
    if (evt_valid !== 1'b0 || drop_count !== 8'd1) begin
      n_err++;
      $display("FAIL drop_handshake: v=%b drop=%0d, required 0/1", evt_valid, drop_count);
    end
    evt_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    evt_ready = 1'b0;
    for (int p = 0; p < STABLE; p++) poll(32'h01, 32'h01, -1);
    for (int p = 0; p < STABLE - 1; p++) poll(32'h03, 32'h03, -1);
    poll(32'h03, 32'h03, 1);
    n_cmp++;
    if (evt_valid !== 1'b1 || evt_data !== 16'h0203 || drop_count !== 8'd0 ||
        switch_state !== 8'h03) begin
      n_err++;
      $display("FAIL b2b_reload: v=%b data=%h drop=%0d sw=%h, required 1/0203/0/03",
               evt_valid, evt_data, drop_count, switch_state);
    end
    tick();
    n_cmp++;
    if (evt_valid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_clear: v=%b, required 0", evt_valid);
    end
    evt_ready = 1'b0;
  endtask

  task automatic test_drop_saturate();
    do_reset();
    evt_ready = 1'b0;
    for (int e = 0; e < 258; e++) begin
      logic [31:0] v;
      v = (e % 2 == 0) ? 32'h01 : 32'h02;
      for (int p = 0; p < STABLE; p++) poll(v, v, -1);
      if (e == 254) begin
        n_cmp++;
        if (drop_count !== 8'd254) begin
          n_err++;
          $display("FAIL drop_count_254: got %0d, required 254", drop_count);
        end
      end
    end
    n_cmp++;
    if (drop_count !== 8'd255 || evt_data !== 16'h0101 || switch_state !== 8'h02) begin
      n_err++;
      $display("FAIL drop_saturate: drop=%0d data=%h sw=%h, required 255/0101/02",
               drop_count, evt_data, switch_state);
    end
  endtask

  task automatic test_reset_mid_poll();
    int cyc;
    readdata = 32'hFF;
    cyc = 0;
    while (!read && cyc < 20) begin
      tick();
      cyc++;
    end
    n_cmp++;
    if (read !== 1'b1) begin
      n_err++;
      $display("FAIL midreset_find_read: read=%b, required 1", read);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++;
    if ({read, switch_state, evt_valid, evt_data, drop_count} !== '0) begin
      n_err++;
      $display("FAIL midreset_outputs: read=%b sw=%h v=%b data=%h drop=%0d, required all 0",
               read, switch_state, evt_valid, evt_data, drop_count);
    end
    cyc = 0;
    while (!read && cyc < 20) begin
      tick();
      cyc++;
    end
    n_cmp++;
    if (cyc != POLL) begin
      n_err++;
      $display("FAIL midreset_read_latency: got %0d cycles, required %0d", cyc, POLL);
    end
    for (int p = 0; p < STABLE - 1; p++) begin
      poll(32'hFF, 32'hFF, -1);
      n_cmp++;
      if (evt_valid !== 1'b0 || switch_state !== 8'h00) begin
        n_err++;
        $display("FAIL midreset_early%0d: v=%b sw=%h, required 0/00", p, evt_valid, switch_state);
      end
    end
    poll(32'hFF, 32'hFF, -1);
    n_cmp++;
    if (evt_valid !== 1'b1 || evt_data !== 16'hFFFF || switch_state !== 8'hFF) begin
      n_err++;
      $display("FAIL midreset_accept: v=%b data=%h sw=%h, required 1/FFFF/FF",
               evt_valid, evt_data, switch_state);
    end
  endtask

  task automatic test_upper_bits();
    do_reset();
    evt_ready = 1'b1;
    for (int p = 0; p < STABLE + 1; p++) begin
      poll(32'hFFFF_FF00, 32'hFFFF_FFAA, -1);
      n_cmp++;
      if (evt_valid !== 1'b0 || switch_state !== 8'h00 || drop_count !== 8'd0) begin
        n_err++;
        $display("FAIL upper_bits%0d: v=%b sw=%h drop=%0d, required 0/00/0",
                 p, evt_valid, switch_state, drop_count);
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    readdata  = 32'h0;
    evt_ready = 1'b0;
    test_reset();
    test_idle();
    test_glitch();
    test_change();
    test_drop();
    test_back_to_back();
    test_drop_saturate();
    test_reset_mid_poll();
    test_upper_bits();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
